// File: rtl/keypad_countdown_timer_pkg.sv
// rtl/keypad_countdown_timer_pkg.sv - shared BCD digit types and constants for the keypad countdown timer
package keypad_countdown_timer_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t DIGIT_MAX     = 4'd9;
    localparam bcd_t SEC_TENS_WRAP = 4'd5;
    localparam bcd_t DIGIT_ZERO    = 4'd0;

    // keypad codes above 9 are not digits and must never be shifted in
    function automatic logic is_bcd(input bcd_t d);
        return d <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/keypad_countdown_timer_if.sv
// rtl/keypad_countdown_timer_if.sv - keypad/tick inputs and digit outputs of the countdown timer
interface keypad_countdown_timer_if ();
    import keypad_countdown_timer_pkg::*;

    bcd_t D;
    logic loadn;
    logic pgt_1Hz;
    logic count_en;
    bcd_t sec_ones;
    bcd_t sec_tens;
    bcd_t min_ones;
    logic zero;

    // master drives the keypad and tick source, slave is the timer
    modport master (
        output D, loadn, pgt_1Hz, count_en,
        input  sec_ones, sec_tens, min_ones, zero
    );

    modport slave (
        input  D, loadn, pgt_1Hz, count_en,
        output sec_ones, sec_tens, min_ones, zero
    );

endinterface

// File: rtl/keypad_countdown_timer_bcd_digit_down.sv
// rtl/keypad_countdown_timer_bcd_digit_down.sv - one BCD down-counting digit with parallel load and borrow
module bcd_digit_down
    import keypad_countdown_timer_pkg::*;
#(
    parameter bcd_t WRAP = DIGIT_MAX
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic load,
    input  bcd_t load_val_i,
    input  logic dec_in,
    output bcd_t digit_o,
    output logic borrow_out
);

    bcd_t digit_q;
    bcd_t digit_d;

    // load wins over decrement; a decrement from 0 wraps to WRAP and borrows
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val_i;
        end else if (dec_in) begin
            digit_d = (digit_q == DIGIT_ZERO) ? WRAP : digit_q - 4'd1;
        end
    end

    // digit storage, cleared synchronously
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            digit_q <= DIGIT_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o    = digit_q;
    assign borrow_out = dec_in & (digit_q == DIGIT_ZERO);

endmodule

// File: rtl/keypad_countdown_timer.sv
// rtl/keypad_countdown_timer.sv - M:SS keypad-loaded BCD countdown timer; KCT_DONE_PULSE_EN adds done_pulse
module keypad_countdown_timer
    import keypad_countdown_timer_pkg::*;
(
    input  logic clock_100Hz,
    input  logic clear,
    keypad_countdown_timer_if.slave bus
`ifdef KCT_DONE_PULSE_EN
    ,
    output logic done_pulse
`endif
);

    logic loadn_q;
    logic pgt_q;
    logic load_evt;
    logic tick_evt;
    logic shift_en;
    logic dec_en;
    logic ones_borrow;
    logic tens_borrow;
    logic min_borrow;
    logic zero;
    bcd_t sec_ones;
    bcd_t sec_tens;
    bcd_t min_ones;

    // edge detectors; reset values hide a key or tick already active at release
    always_ff @(posedge clock_100Hz) begin
        if (clear) begin
            loadn_q <= 1'b0;
            pgt_q   <= 1'b1;
        end else begin
            loadn_q <= bus.loadn;
            pgt_q   <= bus.pgt_1Hz;
        end
    end

    assign load_evt = loadn_q & ~bus.loadn;
    assign tick_evt = ~pgt_q & bus.pgt_1Hz;
    assign zero     = (sec_ones == DIGIT_ZERO) && (sec_tens == DIGIT_ZERO) && (min_ones == DIGIT_ZERO);

    // count_en selects the mode, so a shift and a decrement can never coincide
    assign shift_en = load_evt & ~bus.count_en & is_bcd(bus.D);
    assign dec_en   = tick_evt & bus.count_en & ~zero;

    bcd_digit_down #(.WRAP(DIGIT_MAX)) u_sec_ones (
        .clk_i      (clock_100Hz),
        .clear_i    (clear),
        .load       (shift_en),
        .load_val_i (bus.D),
        .dec_in     (dec_en),
        .digit_o    (sec_ones),
        .borrow_out (ones_borrow)
    );

    bcd_digit_down #(.WRAP(SEC_TENS_WRAP)) u_sec_tens (
        .clk_i      (clock_100Hz),
        .clear_i    (clear),
        .load       (shift_en),
        .load_val_i (sec_ones),
        .dec_in     (ones_borrow),
        .digit_o    (sec_tens),
        .borrow_out (tens_borrow)
    );

    bcd_digit_down #(.WRAP(DIGIT_MAX)) u_min_ones (
        .clk_i      (clock_100Hz),
        .clear_i    (clear),
        .load       (shift_en),
        .load_val_i (sec_tens),
        .dec_in     (tens_borrow),
        .digit_o    (min_ones),
        .borrow_out (min_borrow)
    );

    // the zero guard on dec_en means the minutes digit can never borrow
    always_ff @(posedge clock_100Hz) begin
        if (!clear) begin
            assert (!min_borrow);
        end
    end

    assign bus.sec_ones = sec_ones;
    assign bus.sec_tens = sec_tens;
    assign bus.min_ones = min_ones;
    assign bus.zero     = zero;

`ifdef KCT_DONE_PULSE_EN
    logic done_q;
    logic done_d;

    assign done_d = dec_en && (sec_ones == 4'd1) && (sec_tens == DIGIT_ZERO) && (min_ones == DIGIT_ZERO);

    // one-cycle flag for the tick that reaches 0:00
    always_ff @(posedge clock_100Hz) begin
        if (clear) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done_pulse = done_q;
`endif

endmodule

// File: tb/tb_keypad_countdown_timer.sv
// tb/tb_keypad_countdown_timer.sv - directed self-checking bench for keypad_countdown_timer
module tb_keypad_countdown_timer;

    logic clk = 1'b0;
    logic clear;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    keypad_countdown_timer_if kif ();

`ifdef KCT_DONE_PULSE_EN
    logic done_pulse;
`endif

    keypad_countdown_timer dut (
        .clock_100Hz (clk),
        .clear       (clear),
        .bus         (kif)
`ifdef KCT_DONE_PULSE_EN
        ,
        .done_pulse  (done_pulse)
`endif
    );

    always #5 clk = ~clk;

`ifdef KCT_DONE_PULSE_EN
    always @(posedge clk) begin
        if (done_pulse) done_cnt <= done_cnt + 1;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        kif.D = d;
        kif.loadn = 1'b0;
        step(5);
        kif.loadn = 1'b1;
        step(2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            kif.pgt_1Hz = 1'b1;
            step(2);
            kif.pgt_1Hz = 1'b0;
            step(2);
        end
    endtask

    task automatic check_digits(input string tag, input logic [11:0] exp);
        @(negedge clk);
        check(tag, {20'd0, kif.min_ones, kif.sec_tens, kif.sec_ones}, {20'd0, exp});
    endtask

    initial begin
        clear        = 1'b1;
        kif.D        = 4'd0;
        kif.loadn    = 1'b1;
        kif.pgt_1Hz  = 1'b0;
        kif.count_en = 1'b0;
        step(3);
        check_digits("reset_digits", 12'h000);
        check("reset_zero", {31'd0, kif.zero}, 32'd1);
        clear = 1'b0;
        step(2);

        press(4'd1);
        check_digits("entry_1", 12'h001);
        press(4'd3);
        check_digits("entry_13", 12'h013);
        press(4'd0);
        check_digits("entry_130", 12'h130);
        check("entry_zero", {31'd0, kif.zero}, 32'd0);

        kif.count_en = 1'b1;
        ticks(1);
        check_digits("count_129", 12'h129);
        ticks(30);
        check_digits("count_059", 12'h059);
        ticks(59);
        check_digits("count_000", 12'h000);
        check("count_zero", {31'd0, kif.zero}, 32'd1);
`ifdef KCT_DONE_PULSE_EN
        check("done_once", done_cnt, 32'd1);
`endif

        ticks(3);
        check_digits("floor_000", 12'h000);
`ifdef KCT_DONE_PULSE_EN
        check("floor_done", done_cnt, 32'd1);
`endif

        press(4'd7);
        check_digits("reject_cnt_en", 12'h000);
        kif.count_en = 1'b0;
        press(4'hB);
        check_digits("reject_hex_b", 12'h000);

        press(4'd9);
        press(4'd5);
        check_digits("entry_095", 12'h095);
        kif.count_en = 1'b1;
        ticks(1);
        check_digits("tens9_094", 12'h094);
        ticks(5);
        check_digits("tens9_089", 12'h089);

        kif.count_en = 1'b0;
        press(4'd0);
        press(4'd4);
        press(4'd5);
        check_digits("entry_045", 12'h045);
        kif.count_en = 1'b1;
        step(2);
        kif.D       = 4'd5;
        kif.loadn   = 1'b0;
        kif.pgt_1Hz = 1'b1;
        clear       = 1'b1;
        step(1);
        kif.count_en = 1'b0;
        step(1);
        check_digits("clear_digits", 12'h000);
        check("clear_pgt_q", {31'd0, dut.pgt_q}, 32'd1);
        check("clear_loadn_q", {31'd0, dut.loadn_q}, 32'd0);
        clear = 1'b0;
        step(3);
        check_digits("release_no_load", 12'h000);
        check("release_zero", {31'd0, kif.zero}, 32'd1);
        kif.loadn   = 1'b1;
        kif.pgt_1Hz = 1'b0;
        step(2);

        press(4'd1);
        press(4'd0);
        check_digits("entry_010", 12'h010);
        ticks(2);
        check_digits("freeze_010", 12'h010);
        kif.count_en = 1'b1;
        ticks(1);
        check_digits("resume_009", 12'h009);
`ifdef KCT_DONE_PULSE_EN
        check("done_final", done_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_countdown_timer.md
KEYPAD_COUNTDOWN_TIMER -- requirements
Module: keypad_countdown_timer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
- clock_100Hz  input  1  system clock; all state changes on its rising edge.
- clear  input  1  synchronous, active-high reset.
REQ-002 The module SHALL have these data ports:
- D  input  4  BCD digit from the keypad encoder.
- loadn  input  1  active-low key-valid strobe; low while a key is held.
- pgt_1Hz  input  1  1 Hz waveform; each positive-going transition is one tick.
- count_en  input  1  1 = countdown mode, 0 = entry mode.
- sec_ones  output  4  BCD seconds-units digit.
- sec_tens  output  4  BCD seconds-tens digit.
- min_ones  output  4  BCD minutes digit.
- zero  output  1  high when all three digits are 0.

Function
REQ-003 Load event: load_evt SHALL be loadn_q & ~loadn, where loadn_q is loadn registered one cycle.
REQ-004 Tick event: tick_evt SHALL be ~pgt_q & pgt_1Hz, where pgt_q is pgt_1Hz registered one cycle.
REQ-005 Digit registers SHALL update at the same clock edge at which an event is sampled, and SHALL be visible on the outputs one cycle later.
REQ-006 A load event with count_en=0 and D<=9 SHALL shift the digits left: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
REQ-007 A load event with D>9, or with count_en=1, SHALL be ignored.
REQ-008 Holding loadn low SHALL produce exactly one shift.
REQ-009 A tick event with count_en=1 and zero=0 SHALL decrement MM:SS by one second, in BCD:
- sec_ones 0 -> 9, with a borrow to sec_tens;
- sec_tens 0 -> 5, with a borrow to min_ones;
- otherwise the digit decrements by 1.
REQ-010 Entered sec_tens values 6-9 SHALL decrement normally (for example 0:95 -> 0:94 -> ... -> 0:00).
REQ-011 A tick with zero=1 SHALL leave all digits at 0; the timer never wraps below 0:00.
REQ-012 A tick with count_en=0 SHALL be ignored.
REQ-013 zero SHALL be decoded combinationally from the digit registers, with no added latency.
REQ-014 Event priority SHALL be: clear > tick (count_en=1) > load (count_en=0).
REQ-015 Load and tick are mutually exclusive by mode, so they never conflict.
REQ-016 Changing count_en mid-count SHALL freeze the digits; counting resumes from the frozen value.

Reset
REQ-017 On clear=1, the module SHALL reset:
- sec_ones, sec_tens, min_ones to 0, so zero=1;
- loadn_q to 0, which suppresses a false load if loadn is low at release;
- pgt_q to 1, which suppresses a false tick if pgt_1Hz is high at release.
REQ-018 A clear asserted mid-countdown or mid-entry SHALL take effect at the next edge and discard any pending event.

Configuration
REQ-019 With KCT_DONE_PULSE_EN defined, the module SHALL add an output port done_pulse (output, 1 bit).
- done_pulse is registered and high for exactly one cycle after a tick moves the count from 0:01 to 0:00.
- done_pulse is 0 on reset.
- Loads and clear never assert done_pulse.
REQ-020 Without KCT_DONE_PULSE_EN, the done_pulse port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-021 A shared package SHALL hold the following, reused by the timer display and control blocks:
- the BCD digit width (4);
- DIGIT_MAX=9 and SEC_TENS_WRAP=5;
- the zero-digit constant.
REQ-022 The design SHALL have one sub-module, bcd_digit_down: a 4-bit down digit with parameterized wrap value, inputs dec_in and load, and output borrow_out asserted when the digit is 0 and decrementing.
REQ-023 keypad_countdown_timer SHALL instantiate bcd_digit_down three times, with wrap values 9, 5 and 9.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Entry: count_en=0; press keys 1, 3, 0 (each loadn low for 5 cycles) -> digits 1:30, zero=0, exactly 3 shifts.
- Countdown: from 1:30, count_en=1, give 1 tick -> 1:29; give 30 more ticks -> 0:59; give 59 more ticks -> 0:00 with zero=1 (done_pulse=1 for one cycle when enabled).
- Floor: at 0:00 with count_en=1, give 3 ticks -> the count stays 0:00 and done_pulse stays 0.
- Rejection: count_en=1 with loadn pulsed and D=7 -> no change; count_en=0 with D=4'hB -> no change.
- Reset: clear mid-countdown at 0:45 with pgt_1Hz and loadn held asserted across release -> 0:00, and no tick or load event in the first cycle after release.
- Freeze: at 0:10, drop count_en, give 2 ticks -> the count holds 0:10; raise count_en, give 1 tick -> 0:09.
